// File: rtl/sr_latch_cmd_gen.sv
// Command stage for a gated SR latch: synchronises and debounces two push buttons,
// then turns each clean press into a bounded en/s or en/r window, never s and r together.
module sr_latch_cmd_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_LEN       = 2,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic set_btn,
  input  logic rst_btn,
  output logic s,
  output logic r,
  output logic en,
  output logic busy,
  output logic err
);

  // state | meaning
  // IDLE  | waiting for a press event
  // DRIVE | en high with s or r held for PULSE_LEN cycles
  // HOLD  | outputs low until both buttons are released (debounced)
  typedef enum logic [1:0] {IDLE, DRIVE, HOLD} state_t;

  localparam logic [CNT_W-1:0] DB_TC    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_LEN - 1);

  // bit 0 = set channel, bit 1 = reset channel
  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [1:0]       stable;
  logic [1:0]       stable_d;
  logic [CNT_W-1:0] db_cnt [2];
  logic [1:0]       press;

  state_t           state;
  logic [CNT_W-1:0] pulse_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_d <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1    <= {rst_btn, set_btn};
      sync2    <= sync1;
      stable_d <= stable;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != stable[i]) begin
          if (db_cnt[i] == DB_TC) begin
            stable[i] <= ~stable[i];
            db_cnt[i] <= '0;
          end else if (db_cnt[i] != '1) begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign press = stable & ~stable_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      s         <= 1'b0;
      r         <= 1'b0;
      en        <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      pulse_cnt <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (press == 2'b11) begin
            err   <= 1'b1;
            busy  <= 1'b1;
            state <= HOLD;
          end else if (press[0]) begin
            s         <= 1'b1;
            r         <= 1'b0;
            en        <= 1'b1;
            busy      <= 1'b1;
            pulse_cnt <= PULSE_LD;
            state     <= DRIVE;
          end else if (press[1]) begin
            s         <= 1'b0;
            r         <= 1'b1;
            en        <= 1'b1;
            busy      <= 1'b1;
            pulse_cnt <= PULSE_LD;
            state     <= DRIVE;
          end
        end
        DRIVE: begin
          if (pulse_cnt == '0) begin
            s     <= 1'b0;
            r     <= 1'b0;
            en    <= 1'b0;
            state <= HOLD;
          end else begin
            pulse_cnt <= pulse_cnt - 1'b1;
          end
        end
        HOLD: begin
          // presses seen here are dropped; wait for a full release first
          if (stable == 2'b00) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_latch_cmd_gen.sv
// Bench for sr_latch_cmd_gen: directed timing checks plus randomized button traffic
// compared every cycle against a history-based behavioural model.
module tb_sr_latch_cmd_gen;

  localparam int DEB = 4;
  localparam int PUL = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic set_btn = 1'b0;
  logic rst_btn = 1'b0;
  logic s, r, en, busy, err;
  logic q = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_on = 1'b0;

  sr_latch_cmd_gen #(.DEBOUNCE_CYCLES(DEB), .PULSE_LEN(PUL), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .set_btn(set_btn), .rst_btn(rst_btn),
    .s(s), .r(r), .en(en), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // downstream gated SR latch
  always @(s or r or en) if (en) begin
    if (s) q = 1'b1;
    else if (r) q = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit hist_s[$], hist_r[$];
  bit m_p1_s, m_p1_r, m_sy_s, m_sy_r;
  bit m_stab_s, m_stab_r, m_rose_s, m_rose_r;
  int m_phase, m_rem;
  bit m_s, m_r, m_en, m_busy, m_err;

  // stable level flips once the last DEB synchronised samples all disagree with it
  function automatic bit all_differ(input bit h[$], input bit lvl);
    if (h.size() < DEB) return 1'b0;
    foreach (h[k]) if (h[k] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_s.delete(); hist_r.delete();
      m_p1_s = 0; m_p1_r = 0; m_sy_s = 0; m_sy_r = 0;
      m_stab_s = 0; m_stab_r = 0; m_rose_s = 0; m_rose_r = 0;
      m_phase = 0; m_rem = 0;
      m_s = 0; m_r = 0; m_en = 0; m_busy = 0; m_err = 0;
    end else begin
      m_err = 0;
      case (m_phase)
        0: begin
          if (m_rose_s && m_rose_r) begin
            m_err = 1; m_busy = 1; m_phase = 2;
          end else if (m_rose_s || m_rose_r) begin
            m_s = m_rose_s; m_r = !m_rose_s; m_en = 1; m_busy = 1;
            m_rem = PUL; m_phase = 1;
          end
        end
        1: begin
          m_rem--;
          if (m_rem == 0) begin
            m_s = 0; m_r = 0; m_en = 0; m_phase = 2;
          end
        end
        default: if (!m_stab_s && !m_stab_r) begin
          m_busy = 0; m_phase = 0;
        end
      endcase
      hist_s.push_back(m_sy_s); if (hist_s.size() > DEB) void'(hist_s.pop_front());
      hist_r.push_back(m_sy_r); if (hist_r.size() > DEB) void'(hist_r.pop_front());
      m_rose_s = 0; m_rose_r = 0;
      if (all_differ(hist_s, m_stab_s)) begin m_stab_s = !m_stab_s; m_rose_s = m_stab_s; end
      if (all_differ(hist_r, m_stab_r)) begin m_stab_r = !m_stab_r; m_rose_r = m_stab_r; end
      m_sy_s = m_p1_s; m_sy_r = m_p1_r;
      m_p1_s = set_btn; m_p1_r = rst_btn;
    end
  end

  always @(negedge clk) if (chk_on && !rst) begin
    check("model_s", s, m_s);
    check("model_r", r, m_r);
    check("model_en", en, m_en);
    check("model_busy", busy, m_busy);
    check("model_err", err, m_err);
    check("inv_s_and_r", s & r, 0);
    check("inv_sr_needs_en", (s | r) & ~en, 0);
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_en(input string tag, input int budget);
    int n = 0;
    while (!en && n < budget) begin tick(); n++; end
    check(tag, en, 1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin tick(); n++; end
    check(tag, busy, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_s", s, 0); check("rst_r", r, 0); check("rst_en", en, 0);
    check("rst_busy", busy, 0); check("rst_err", err, 0);
    @(negedge clk); rst = 1'b0; chk_on = 1'b1;
    repeat (3) tick();

    // clean set press: window after edges 6..7
    @(negedge clk); set_btn = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t1_en", en, (k == 6 || k == 7));
      check("t1_s", s, (k == 6 || k == 7));
      check("t1_r", r, 0);
      check("t1_busy", busy, (k >= 6));
    end
    check("t1_q", q, 1);
    @(negedge clk); set_btn = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("t1_release_busy", busy, (k < 6));
    end

    // clean reset press
    @(negedge clk); rst_btn = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t2_en", en, (k == 6 || k == 7));
      check("t2_r", r, (k == 6 || k == 7));
      check("t2_s", s, 0);
    end
    check("t2_q", q, 0);
    @(negedge clk); rst_btn = 1'b0;
    wait_idle("t2_idle", 20);

    // glitches shorter than the debounce window
    @(negedge clk); set_btn = 1'b1;
    repeat (3) @(negedge clk); set_btn = 1'b0;
    repeat (3) @(negedge clk); set_btn = 1'b1;
    repeat (2) @(negedge clk); set_btn = 1'b0;
    for (int k = 0; k < 14; k++) begin
      tick();
      check("t3_busy", busy, 0); check("t3_en", en, 0); check("t3_err", err, 0);
    end

    // simultaneous press
    @(negedge clk); set_btn = 1'b1; rst_btn = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t4_err", err, (k == 6));
      check("t4_busy", busy, (k >= 6));
      check("t4_en", en | s | r, 0);
    end
    @(negedge clk); set_btn = 1'b0; rst_btn = 1'b0;
    wait_idle("t4_idle", 20);

    // second button during a command is ignored until both released
    @(negedge clk); set_btn = 1'b1;
    wait_en("t5_en", 20);
    @(negedge clk); rst_btn = 1'b1;
    repeat (10) tick();
    @(negedge clk); set_btn = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      check("t5_no_r", r, 0);
      check("t5_busy", busy, 1);
    end
    @(negedge clk); rst_btn = 1'b0;
    wait_idle("t5_idle", 20);
    @(negedge clk); rst_btn = 1'b1;
    wait_en("t5_r_en", 20);
    check("t5_r", r, 1);
    @(negedge clk); rst_btn = 1'b0;
    wait_idle("t5_idle2", 20);

    // reset mid-DRIVE with set still held
    @(negedge clk); set_btn = 1'b1;
    wait_en("t6_en", 20);
    #1 rst = 1'b1;
    #1;
    check("t6_async_en", en, 0); check("t6_async_s", s, 0); check("t6_async_busy", busy, 0);
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 9; k++) begin
      tick();
      check("t6_re_en", en, (k == 6 || k == 7));
      check("t6_re_s", s, (k == 6 || k == 7));
    end
    @(negedge clk); set_btn = 1'b0;
    wait_idle("t6_idle", 20);

    // randomized traffic against the model
    for (int seg = 0; seg < 300; seg++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        repeat ($urandom_range(1, 2)) @(negedge clk);
        rst = 1'b0;
      end
      set_btn = 1'($urandom_range(0, 1));
      rst_btn = ($urandom_range(0, 3) == 0) ? set_btn : 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 11)) @(negedge clk);
    end
    @(negedge clk); set_btn = 1'b0; rst_btn = 1'b0;
    wait_idle("final_idle", 40);
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
